// File: rtl/dsp_mac_casc_model_if.sv
// Operand/result bundle of one PE multiply-accumulate slice.
// master: drives operands, OPMODE, C, cascade-in and valid_i; receives P/PCOUT/valid_o.
// slave : the MAC slice itself.
interface dsp_mac_casc_model_if #(
    parameter int unsigned WIDTH  = 17,
    parameter int unsigned PWIDTH = 48
);
    logic                 valid_i;
    logic                 CREG_en_i;
    logic [6:0]           OPMODE_i;
    logic [WIDTH-1:0]     A_i;
    logic [WIDTH-1:0]     B_i;
    logic [2*WIDTH-1:0]   C_i;
    logic [PWIDTH-1:0]    PCIN_i;
    logic [2*WIDTH-1:0]   P_o;
    logic [PWIDTH-1:0]    PCOUT_o;
    logic                 valid_o;

    modport master (
        output valid_i, CREG_en_i, OPMODE_i, A_i, B_i, C_i, PCIN_i,
        input  P_o, PCOUT_o, valid_o
    );

    modport slave (
        input  valid_i, CREG_en_i, OPMODE_i, A_i, B_i, C_i, PCIN_i,
        output P_o, PCOUT_o, valid_o
    );
endinterface

// File: rtl/dsp_mac_casc_model.sv
// Behavioural, vendor-independent model of the PE multiply-accumulate slice.
// P <= X + Y + Z (mod 2^PWIDTH), with X/Y/Z chosen at runtime by OPMODE
// (X=[1:0], Y=[3:2], Z=[6:4]); valid_o tracks valid_i through 1+ABREG+MREG stages.
// Ports: clock_i (rising edge), reset_i (sync, active high), bus (slave modport):
//   valid_i, CREG_en_i, OPMODE_i, A_i, B_i, C_i, PCIN_i in; P_o, PCOUT_o, valid_o out.
// Optional macro DSP_CASC_SHIFT_EN: enables Z=101 (PCIN>>WIDTH) and Z=110 (P>>WIDTH).
module dsp_mac_casc_model #(
    parameter int unsigned WIDTH     = 17,
    parameter int unsigned PWIDTH    = 48,
    parameter int unsigned ABREG     = 1,
    parameter int unsigned MREG      = 1,
    parameter int unsigned CREG      = 1,
    parameter int unsigned OPMODEREG = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    dsp_mac_casc_model_if.slave   bus
);
    localparam int unsigned DSP_REG_LEVEL = 1 + ABREG + MREG;
    localparam int unsigned MW            = 2 * WIDTH;

    // Elaboration-time parameter legality check
    if (ABREG > 2 || MREG > 1 || CREG > 1 || OPMODEREG > 1 || PWIDTH < MW + 2) begin : g_bad_param
        $error("dsp_mac_casc_model: illegal parameter combination");
    end

    logic [WIDTH-1:0]  a_s, b_s;
    logic [MW-1:0]     m_c, m_s, c_s;
    logic [6:0]        opmode_s;
    logic [PWIDTH-1:0] p_q, p_d;
    logic [PWIDTH-1:0] x_c, y_c, z_c;
    logic [DSP_REG_LEVEL-1:0] vld_q, vld_d;

    // A/B input pipeline, always enabled
    if (ABREG == 0) begin : g_ab_comb
        assign a_s = bus.A_i;
        assign b_s = bus.B_i;
    end else begin : g_ab_reg
        logic [WIDTH-1:0] a_q [ABREG];
        logic [WIDTH-1:0] b_q [ABREG];
        logic [WIDTH-1:0] a_d [ABREG];
        logic [WIDTH-1:0] b_d [ABREG];

        always_comb begin
            a_d[0] = bus.A_i;
            b_d[0] = bus.B_i;
            for (int i = 1; i < int'(ABREG); i++) begin
                a_d[i] = a_q[i-1];
                b_d[i] = b_q[i-1];
            end
        end

        always_ff @(posedge clock_i) begin
            for (int i = 0; i < int'(ABREG); i++) begin
                if (reset_i) begin
                    a_q[i] <= '0;
                    b_q[i] <= '0;
                end else begin
                    a_q[i] <= a_d[i];
                    b_q[i] <= b_d[i];
                end
            end
        end

        assign a_s = a_q[ABREG-1];
        assign b_s = b_q[ABREG-1];
    end

    // Unsigned full-width product
    assign m_c = MW'(a_s) * MW'(b_s);

    if (MREG == 0) begin : g_m_comb
        assign m_s = m_c;
    end else begin : g_m_reg
        logic [MW-1:0] m_q, m_d;
        always_comb m_d = m_c;
        always_ff @(posedge clock_i) begin
            if (reset_i) m_q <= '0;
            else         m_q <= m_d;
        end
        assign m_s = m_q;
    end

    // C addend, register holds unless enabled
    if (CREG == 0) begin : g_c_comb
        logic unused_c_en;
        assign unused_c_en = bus.CREG_en_i;
        assign c_s = bus.C_i;
    end else begin : g_c_reg
        logic [MW-1:0] c_q, c_d;
        always_comb begin
            c_d = c_q;
            if (bus.CREG_en_i) c_d = bus.C_i;
        end
        always_ff @(posedge clock_i) begin
            if (reset_i) c_q <= '0;
            else         c_q <= c_d;
        end
        assign c_s = c_q;
    end

    if (OPMODEREG == 0) begin : g_op_comb
        assign opmode_s = bus.OPMODE_i;
    end else begin : g_op_reg
        logic [6:0] opmode_q, opmode_d;
        always_comb opmode_d = bus.OPMODE_i;
        always_ff @(posedge clock_i) begin
            if (reset_i) opmode_q <= '0;
            else         opmode_q <= opmode_d;
        end
        assign opmode_s = opmode_q;
    end

    // X/Y/Z operand muxes and the P adder; overflow wraps silently
    always_comb begin
        x_c = '0;
        y_c = '0;
        z_c = '0;
        case (opmode_s[1:0])
            2'b01:   x_c = PWIDTH'(m_s);
            2'b10:   x_c = p_q;
            default: x_c = '0;
        endcase
        if (opmode_s[3:2] == 2'b11) y_c = PWIDTH'(c_s);
        case (opmode_s[6:4])
            3'b001:  z_c = bus.PCIN_i;
            3'b010:  z_c = p_q;
            3'b011:  z_c = PWIDTH'(c_s);
`ifdef DSP_CASC_SHIFT_EN
            3'b101:  z_c = bus.PCIN_i >> WIDTH;
            3'b110:  z_c = p_q >> WIDTH;
`endif
            default: z_c = '0;
        endcase
        p_d = x_c + y_c + z_c;
    end

    // valid tracker; never gates the datapath
    always_comb vld_d = (vld_q << 1) | DSP_REG_LEVEL'(bus.valid_i);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            p_q   <= '0;
            vld_q <= '0;
        end else begin
            p_q   <= p_d;
            vld_q <= vld_d;
        end
    end

    assign bus.P_o     = p_q[MW-1:0];
    assign bus.PCOUT_o = p_q;
    assign bus.valid_o = vld_q[DSP_REG_LEVEL-1];
endmodule

// File: tb/tb_dsp_mac_casc_model.sv
// Directed bench for dsp_mac_casc_model: steady-state vector table on the default
// configuration plus hand-written multi-cycle sequences and two alternate pipelines.
module tb_dsp_mac_casc_model;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dsp_mac_casc_model_if #(.WIDTH(17), .PWIDTH(48)) bus0 ();
    dsp_mac_casc_model_if #(.WIDTH(17), .PWIDTH(48)) bus1 ();
    dsp_mac_casc_model_if #(.WIDTH(17), .PWIDTH(48)) bus2 ();

    dsp_mac_casc_model u0 (.clock_i(clk), .reset_i(rst), .bus(bus0));

    dsp_mac_casc_model #(.ABREG(2), .MREG(0)) u1 (.clock_i(clk), .reset_i(rst), .bus(bus1));

    dsp_mac_casc_model #(.ABREG(0), .MREG(0), .CREG(0), .OPMODEREG(0)) u2 (
        .clock_i(clk), .reset_i(rst), .bus(bus2));

    typedef struct {
        logic [16:0] a;
        logic [16:0] b;
        logic [33:0] c;
        logic [47:0] pcin;
        logic [6:0]  op;   // {Z,Y,X}
        logic [47:0] exp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic [16:0] a, input logic [16:0] b, input logic [33:0] c,
                          input logic [47:0] pcin, input logic [6:0] op);
        bus0.A_i      = a;
        bus0.B_i      = b;
        bus0.C_i      = c;
        bus0.PCIN_i   = pcin;
        bus0.OPMODE_i = op;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [47:0] casc_exp;
`ifdef DSP_CASC_SHIFT_EN
        casc_exp = 48'd4;
`else
        casc_exp = 48'd1;
`endif
        //          a         b         c        pcin                op            exp
        vecs[0] = '{17'h1FFFF, 17'h1FFFF, 34'd0,   48'd0,              7'b000_00_01, 48'h3_FFFC_0001};
        vecs[1] = '{17'd7,     17'd9,     34'd100, 48'd0,              7'b000_11_01, 48'd163};
        vecs[2] = '{17'd3,     17'd4,     34'd5,   48'd0,              7'b011_00_01, 48'd17};
        vecs[3] = '{17'd0,     17'd0,     34'd10,  48'd0,              7'b011_11_01, 48'd20};
        vecs[4] = '{17'd2,     17'd2,     34'd0,   48'h0001_2345_6789, 7'b001_00_01, 48'h1_2345_678D};
        vecs[5] = '{17'd9,     17'd9,     34'd0,   48'd0,              7'b000_00_00, 48'd0};
        vecs[6] = '{17'd9,     17'd9,     34'd55,  48'd0,              7'b100_01_11, 48'd0};
        vecs[7] = '{17'd1,     17'd1,     34'd0,   48'h6_0000,         7'b101_00_01, casc_exp};
        vecs[8] = '{17'd1,     17'd1,     34'd0,   48'hFFFF_FFFF_FFFF, 7'b001_00_01, 48'd0};
        vecs[9] = '{17'd3,     17'd3,     34'd0,   48'd777,            7'b111_00_01, 48'd9};

        rst = 1'b1;
        bus0.valid_i = 1'b0; bus0.CREG_en_i = 1'b1;
        drive0(17'd0, 17'd0, 34'd0, 48'd0, 7'd0);
        bus1.valid_i = 1'b0; bus1.CREG_en_i = 1'b0; bus1.C_i = 34'd0; bus1.PCIN_i = 48'd0;
        bus1.A_i = 17'd0; bus1.B_i = 17'd0; bus1.OPMODE_i = 7'b000_00_01;
        bus2.valid_i = 1'b0; bus2.CREG_en_i = 1'b0; bus2.C_i = 34'd0; bus2.PCIN_i = 48'd0;
        bus2.A_i = 17'd0; bus2.B_i = 17'd0; bus2.OPMODE_i = 7'b000_00_01;
        tick();
        tick();
        chk("reset P_o", 64'(bus0.P_o), 64'd0);
        chk("reset PCOUT_o", 64'(bus0.PCOUT_o), 64'd0);
        chk("reset valid_o", 64'(bus0.valid_o), 64'd0);
        rst = 1'b0;

        // Steady-state table: inputs held until every pipeline has flushed
        for (int i = 0; i < NV; i++) begin
            drive0(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].pcin, vecs[i].op);
            repeat (4) tick();
            chk($sformatf("vec%0d P_o", i), 64'(bus0.P_o), 64'(vecs[i].exp[33:0]));
            chk($sformatf("vec%0d PCOUT_o", i), 64'(bus0.PCOUT_o), 64'(vecs[i].exp));
        end

        // Single-cycle launch: result and valid_o exactly 3 cycles later
        drive0(17'd0, 17'd0, 34'd0, 48'd0, 7'b000_00_01);
        do_reset();
        drive0(17'h1FFFF, 17'h1FFFF, 34'd0, 48'd0, 7'b000_00_01);
        bus0.valid_i = 1'b1;
        tick();
        chk("lat c1 valid_o", 64'(bus0.valid_o), 64'd0);
        bus0.A_i = 17'd0; bus0.B_i = 17'd0; bus0.valid_i = 1'b0;
        tick();
        chk("lat c2 valid_o", 64'(bus0.valid_o), 64'd0);
        chk("lat c2 P_o", 64'(bus0.P_o), 64'd0);
        tick();
        chk("lat c3 valid_o", 64'(bus0.valid_o), 64'd1);
        chk("lat c3 P_o", 64'(bus0.P_o), 64'h3_FFFC_0001);
        tick();
        chk("lat c4 valid_o", 64'(bus0.valid_o), 64'd0);

        // Accumulate M into P, then double P with X=P, Z=P
        drive0(17'd0, 17'd0, 34'd0, 48'd0, 7'b010_00_01);
        do_reset();
        tick();
        tick();
        bus0.A_i = 17'd2; bus0.B_i = 17'd3;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 3) begin
                bus0.A_i = 17'd0; bus0.B_i = 17'd0;
            end
            if (k >= 3) begin
                chk($sformatf("acc c%0d P_o", k), 64'(bus0.P_o),
                    (k == 3) ? 64'd6 : (k == 4) ? 64'd12 : 64'd18);
            end
        end
        bus0.OPMODE_i = 7'b010_00_10;
        tick();
        chk("dbl c1 P_o", 64'(bus0.P_o), 64'd18);
        tick();
        chk("dbl c2 P_o", 64'(bus0.P_o), 64'd36);
        tick();
        chk("dbl c3 P_o", 64'(bus0.P_o), 64'd72);

        // C register holds while CREG_en_i is low
        drive0(17'd0, 17'd0, 34'd100, 48'd0, 7'b000_11_00);
        bus0.CREG_en_i = 1'b1;
        do_reset();
        tick();
        bus0.C_i = 34'd7; bus0.CREG_en_i = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk($sformatf("chold c%0d P_o", k), 64'(bus0.P_o), 64'd100);
        end
        bus0.CREG_en_i = 1'b1;

        // Reset one cycle after launch discards the in-flight product
        drive0(17'd0, 17'd0, 34'd0, 48'd0, 7'b000_00_01);
        do_reset();
        tick();
        bus0.A_i = 17'd5; bus0.B_i = 17'd5; bus0.valid_i = 1'b1;
        tick();
        bus0.A_i = 17'd0; bus0.B_i = 17'd0; bus0.valid_i = 1'b0;
        rst = 1'b1;
        tick();
        chk("abort rst P_o", 64'(bus0.P_o), 64'd0);
        chk("abort rst PCOUT_o", 64'(bus0.PCOUT_o), 64'd0);
        chk("abort rst valid_o", 64'(bus0.valid_o), 64'd0);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("abort c%0d P_o", k), 64'(bus0.P_o), 64'd0);
            chk($sformatf("abort c%0d valid_o", k), 64'(bus0.valid_o), 64'd0);
        end

        // Alternate pipelines: ABREG=2/MREG=0 (3 cycles) and ABREG=0/MREG=0 (1 cycle)
        do_reset();
        tick();
        bus1.A_i = 17'd7; bus1.B_i = 17'd9; bus1.valid_i = 1'b1;
        bus2.A_i = 17'd7; bus2.B_i = 17'd9; bus2.valid_i = 1'b1;
        tick();
        chk("ab0 c1 P_o", 64'(bus2.P_o), 64'd63);
        chk("ab0 c1 valid_o", 64'(bus2.valid_o), 64'd1);
        chk("ab2 c1 P_o", 64'(bus1.P_o), 64'd0);
        bus1.A_i = 17'd0; bus1.B_i = 17'd0; bus1.valid_i = 1'b0;
        bus2.A_i = 17'd0; bus2.B_i = 17'd0; bus2.valid_i = 1'b0;
        tick();
        chk("ab2 c2 P_o", 64'(bus1.P_o), 64'd0);
        chk("ab0 c2 P_o", 64'(bus2.P_o), 64'd0);
        tick();
        chk("ab2 c3 P_o", 64'(bus1.P_o), 64'd63);
        chk("ab2 c3 valid_o", 64'(bus1.valid_o), 64'd1);
        tick();
        chk("ab2 c4 valid_o", 64'(bus1.valid_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
